// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style character LCD driver.
//   state_t   : sequencer states, in the order the panel visits them
//   CNT_W     : width of the per-state cycle counter (longest state is 400 cycles)
//   LINE_LEN  : cycles spent writing one text line (address command + 16 chars)
//   CMD_*     : HD44780 command bytes issued by the sequencer
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_DELAY        = 3'd0,
    ST_FUNCTION_SET = 3'd1,
    ST_DISP_ONOFF   = 3'd2,
    ST_ENTRY_MODE   = 3'd3,
    ST_LINE1        = 3'd4,
    ST_LINE2        = 3'd5,
    ST_DELAY_T      = 3'd6,
    ST_CLEAR_DISP   = 3'd7
  } state_t;

  localparam int CNT_W    = 9;
  localparam int LINE_LEN = 17;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment address, no shift
  localparam logic [7:0] CMD_CLEAR    = 8'h01;  // clear display
  localparam logic [7:0] CMD_LINE1    = 8'h80;  // DDRAM address 0x00
  localparam logic [7:0] CMD_LINE2    = 8'hC0;  // DDRAM address 0x40

endpackage

// File: rtl/lcd_main_text_rom.sv
// Fixed message text for the two display lines, purely combinational.
// Ports:
//   i_line : 0 selects line 1 text, 1 selects line 2 text
//   i_idx  : character position 0..15
//   o_char : ASCII code of that character
module lcd_main_text_rom (
  input  logic       i_line,
  input  logic [3:0] i_idx,
  output logic [7:0] o_char
);

  localparam logic [127:0] TXT_LINE1 = "HELLO WORLD     ";
  localparam logic [127:0] TXT_LINE2 = "  VERILOG  LCD  ";

  // String literals pack the first character in the most significant byte.
  logic [6:0] w_bit_base;

  always_comb begin
    w_bit_base = {(4'd15 - i_idx), 3'b000};
    if (i_line) o_char = TXT_LINE2[w_bit_base +: 8];
    else        o_char = TXT_LINE1[w_bit_base +: 8];
  end

endmodule

// File: rtl/lcd_main.sv
// HD44780-style character LCD driver, 8-bit write-only bus.
// After reset: power-on wait, init commands, then two 16-char text lines;
// afterwards loops forever: hold, clear, rewrite both lines.
// The clock is already slow enough for the panel, so there is no divider.
// Ports:
//   clk         : system clock, rising-edge active
//   resetn      : asynchronous reset, active HIGH despite its name
//   LCD_E       : enable strobe, clk gated by the registered enable
//   LCD_RS      : 0 = command byte, 1 = character data
//   LCD_RW      : tied 0 (write only)
//   LCD_DATA    : command / character byte
//   o_dbg_state : current sequencer state, for observation only
// Outputs are registered from (state, cnt), so what a state "sends" appears
// on the pins one cycle after the state itself; the strobe's falling edge is
// mid-cycle while data is held stable from the rising edge.
module lcd_main
  import lcd_pkg::*;
#(
  parameter int DLY_PWR  = 70,
  parameter int DLY_CMD  = 30,
  parameter int DLY_HOLD = 400,
  parameter int DLY_CLR  = 200
) (
  input  logic       clk,
  input  logic       resetn,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA,
  output state_t     o_dbg_state
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_e_en;
  logic             r_rs;
  logic [7:0]       r_data;

  state_t           w_next_state;
  state_t           w_succ;
  logic [CNT_W-1:0] w_next_cnt;
  logic [CNT_W-1:0] w_last;
  logic             w_e_en;
  logic             w_rs;
  logic [7:0]       w_data;
  logic             w_line_sel;
  logic [3:0]       w_char_idx;
  logic [7:0]       w_char;

  // Character position: cnt 1..16 maps to text index 0..15.
  assign w_char_idx = 4'(r_cnt - CNT_W'(1));
  assign w_line_sel = (r_state == ST_LINE2);

  lcd_main_text_rom u_text_rom (
    .i_line (w_line_sel),
    .i_idx  (w_char_idx),
    .o_char (w_char)
  );

  // Next-state, next-count and next-output logic.
  always_comb begin
    w_succ     = r_state;
    w_last     = CNT_W'(DLY_PWR - 1);
    w_e_en     = 1'b0;
    w_rs       = 1'b0;
    w_data     = 8'h00;
    unique case (r_state)
      ST_DELAY: begin
        w_last = CNT_W'(DLY_PWR - 1);
        w_succ = ST_FUNCTION_SET;
      end
      ST_FUNCTION_SET: begin
        w_last = CNT_W'(DLY_CMD - 1);
        w_succ = ST_DISP_ONOFF;
        w_e_en = 1'b1;
        w_data = CMD_FUNC_SET;
      end
      ST_DISP_ONOFF: begin
        w_last = CNT_W'(DLY_CMD - 1);
        w_succ = ST_ENTRY_MODE;
        w_e_en = 1'b1;
        w_data = CMD_DISP_ON;
      end
      ST_ENTRY_MODE: begin
        w_last = CNT_W'(DLY_CMD - 1);
        w_succ = ST_LINE1;
        w_e_en = 1'b1;
        w_data = CMD_ENTRY;
      end
      ST_LINE1, ST_LINE2: begin
        w_last = CNT_W'(LINE_LEN - 1);
        w_succ = (r_state == ST_LINE1) ? ST_LINE2 : ST_DELAY_T;
        w_e_en = 1'b1;
        // First cycle sets the DDRAM address, the rest stream characters.
        if (r_cnt == '0) begin
          w_rs   = 1'b0;
          w_data = (r_state == ST_LINE1) ? CMD_LINE1 : CMD_LINE2;
        end else begin
          w_rs   = 1'b1;
          w_data = w_char;
        end
      end
      ST_DELAY_T: begin
        w_last = CNT_W'(DLY_HOLD - 1);
        w_succ = ST_CLEAR_DISP;
      end
      ST_CLEAR_DISP: begin
        w_last = CNT_W'(DLY_CLR - 1);
        w_succ = ST_LINE1;
        w_e_en = 1'b1;
        w_data = CMD_CLEAR;
      end
      default: begin
        w_last = '0;
        w_succ = ST_DELAY;
      end
    endcase

    if (r_cnt == w_last) begin
      w_next_state = w_succ;
      w_next_cnt   = '0;
    end else begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state <= ST_DELAY;
      r_cnt   <= '0;
      r_e_en  <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_e_en  <= w_e_en;
      r_rs    <= w_rs;
      r_data  <= w_data;
    end
  end

  // High for the first half of every enabled cycle; falls while data is stable.
  assign LCD_E       = clk & r_e_en;
  assign LCD_RS      = r_rs;
  assign LCD_RW      = 1'b0;
  assign LCD_DATA    = r_data;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lcd_main.sv
`timescale 1ns/1ns
module tb_lcd_main;

  localparam int T_PWR  = 70;
  localparam int T_CMD  = 30;
  localparam int T_HOLD = 400;
  localparam int T_CLR  = 200;
  localparam int T_INIT = T_PWR + 3 * T_CMD;           // cycles before first LINE1
  localparam int T_LOOP = 2 * 17 + T_HOLD + T_CLR;     // one display refresh loop

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;
  logic [2:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected pin pattern per cycle: {E pulses, RS, DATA}
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  lcd_main dut (
    .clk         (clk),
    .resetn      (resetn),
    .LCD_E       (lcd_e),
    .LCD_RS      (lcd_rs),
    .LCD_RW      (lcd_rw),
    .LCD_DATA    (lcd_data),
    .o_dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_n(input int n, input bit e, input bit rs, input logic [7:0] d);
    repeat (n) exp_q.push_back({e, rs, d});
  endtask

  task automatic push_line(input logic [7:0] addr, input string txt);
    push_n(1, 1'b1, 1'b0, addr);
    for (int i = 0; i < 16; i++) push_n(1, 1'b1, 1'b1, 8'(txt[i]));
  endtask

  // Pin behaviour from the first clock edge after reset release.
  task automatic build(input int loops);
    exp_q.delete();
    push_n(T_PWR, 1'b0, 1'b0, 8'h00);
    push_n(T_CMD, 1'b1, 1'b0, 8'h38);
    push_n(T_CMD, 1'b1, 1'b0, 8'h0C);
    push_n(T_CMD, 1'b1, 1'b0, 8'h06);
    for (int l = 0; l < loops; l++) begin
      push_line(8'h80, "HELLO WORLD     ");
      push_line(8'hC0, "  VERILOG  LCD  ");
      push_n(T_HOLD, 1'b0, 1'b0, 8'h00);
      push_n(T_CLR, 1'b1, 1'b0, 8'h01);
    end
  endtask

  // Each cycle: compare pins just after the rising edge (E high phase),
  // then confirm nothing moved while E is still high.
  task automatic run_cycles(input int n);
    logic [9:0] item;
    logic [7:0] d_seen;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("exp_queue_exhausted", 32'd1, 32'd0);
        return;
      end
      item = exp_q.pop_front();
      check("lcd_e", lcd_e, item[9]);
      check("lcd_rs", lcd_rs, item[8]);
      check("lcd_data", lcd_data, item[7:0]);
      check("lcd_rw", lcd_rw, 1'b0);
      d_seen = lcd_data;
      #3;
      check("e_held", lcd_e, item[9]);
      if (lcd_e) check("data_stable_while_e", lcd_data, d_seen);
    end
  endtask

  // Called at posedge+4; asserts reset while clk is low, mid-cycle.
  task automatic do_reset(input int hold);
    #2;
    resetn = 1'b1;
    #1;
    check("rst_async_data", lcd_data, 8'h00);
    check("rst_async_rs", lcd_rs, 1'b0);
    check("rst_async_e", lcd_e, 1'b0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("rst_hold_e", lcd_e, 1'b0);
      check("rst_hold_data", lcd_data, 8'h00);
      check("rst_hold_rs", lcd_rs, 1'b0);
    end
    @(negedge clk);
    #1;
    resetn = 1'b0;
    build(3);
  endtask

  initial begin
    int lp;
    int c;
    #2;
    resetn = 1'b1;
    #1;
    check("por_e", lcd_e, 1'b0);
    check("por_rs", lcd_rs, 1'b0);
    check("por_data", lcd_data, 8'h00);
    check("por_rw", lcd_rw, 1'b0);
    resetn = 1'b0;
    build(5);
    run_cycles(3000);

    do_reset($urandom_range(1, 3));
    for (int r = 0; r < 3; r++) begin
      // Interrupt during the text portion of LINE1 of loop 0 or 1.
      lp = $urandom_range(0, 1);
      c  = $urandom_range(1, 16);
      run_cycles(T_INIT + lp * T_LOOP + c + 1);
      do_reset($urandom_range(1, 3));
    end
    run_cycles(T_INIT + 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
